bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the `Bus` interface. It lets two `Virgule` cores, or a `Virgule` and a DMA/debug master, share one memory/peripheral bus. Arbitration is round-robin and grants are registered. A grant is held until the slave completes the transfer, so a multi-cycle transfer is never split. The block also routes the slave interrupt to one master and keeps per-master completed-transfer counters for debug.

---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with registered grants,
// slave interrupt routing and per-master completed-transfer counters.
module bus_arbiter #(
    parameter int IRQ_TARGET  = 0,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0_valid,
    output logic                   m0_ready,
    input  logic [31:0]            m0_address,
    input  logic [3:0]             m0_wstrobe,
    input  logic [31:0]            m0_wdata,
    output logic [31:0]            m0_rdata,
    output logic                   m0_irq,

    input  logic                   m1_valid,
    output logic                   m1_ready,
    input  logic [31:0]            m1_address,
    input  logic [3:0]             m1_wstrobe,
    input  logic [31:0]            m1_wdata,
    output logic [31:0]            m1_rdata,
    output logic                   m1_irq,

    output logic                   s_valid,
    input  logic                   s_ready,
    output logic [31:0]            s_address,
    output logic [3:0]             s_wstrobe,
    output logic [31:0]            s_wdata,
    input  logic [31:0]            s_rdata,
    input  logic                   s_irq,

    output logic [1:0]             grant,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count0,
    output logic [COUNT_WIDTH-1:0] count1
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;
    logic   last;
    logic   last_next;
    logic   inc0;
    logic   inc1;
    logic   own0;
    logic   own1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            last   <= 1'b1;
            count0 <= '0;
            count1 <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            if (inc0) begin
                count0 <= count0 + ONE;
            end
            if (inc1) begin
                count1 <= count1 + ONE;
            end
        end
    end

    // In OWNk, s_valid mirrors mk.valid, so completion reduces to mk.valid && s_ready.
    always_comb begin
        state_next = state;
        last_next  = last;
        inc0       = 1'b0;
        inc1       = 1'b0;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_next = last ? OWN0 : OWN1;
                end else if (m0_valid) begin
                    state_next = OWN0;
                end else if (m1_valid) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_valid) begin
                    state_next = IDLE;
                end else if (s_ready) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                    inc0       = 1'b1;
                end
            end
            OWN1: begin
                if (!m1_valid) begin
                    state_next = IDLE;
                end else if (s_ready) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                    inc1       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign grant = {own1, own0};
    assign busy  = |grant;

    always_comb begin
        s_valid   = 1'b0;
        s_address = '0;
        s_wstrobe = '0;
        s_wdata   = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        unique case (1'b1)
            own0: begin
                s_valid   = m0_valid;
                s_address = m0_address;
                s_wstrobe = m0_wstrobe;
                s_wdata   = m0_wdata;
                m0_ready  = s_ready;
            end
            own1: begin
                s_valid   = m1_valid;
                s_address = m1_address;
                s_wstrobe = m1_wstrobe;
                s_wdata   = m1_wdata;
                m1_ready  = s_ready;
            end
            default: begin
            end
        endcase
    end

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    assign m0_irq = (IRQ_TARGET == 0) ? s_irq : 1'b0;
    assign m1_irq = (IRQ_TARGET == 1) ? s_irq : 1'b0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: default instance plus a
// second instance with IRQ_TARGET=1 and COUNT_WIDTH=2.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid;
    logic [31:0] m0_address;
    logic [3:0]  m0_wstrobe;
    logic [31:0] m0_wdata;
    logic        m1_valid;
    logic [31:0] m1_address;
    logic [3:0]  m1_wstrobe;
    logic [31:0] m1_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        s_irq;

    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m0_irq;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        m1_irq;
    logic        s_valid;
    logic [31:0] s_address;
    logic [3:0]  s_wstrobe;
    logic [31:0] s_wdata;
    logic [1:0]  grant;
    logic        busy;
    logic [31:0] count0;
    logic [31:0] count1;

    logic        b_m0_ready;
    logic [31:0] b_m0_rdata;
    logic        b_m0_irq;
    logic        b_m1_ready;
    logic [31:0] b_m1_rdata;
    logic        b_m1_irq;
    logic        b_s_valid;
    logic [31:0] b_s_address;
    logic [3:0]  b_s_wstrobe;
    logic [31:0] b_s_wdata;
    logic [1:0]  b_grant;
    logic        b_busy;
    logic [1:0]  b_count0;
    logic [1:0]  b_count1;

    int errors = 0;
    int checks = 0;

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready),
        .m0_address(m0_address), .m0_wstrobe(m0_wstrobe),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_irq(m0_irq),
        .m1_valid(m1_valid), .m1_ready(m1_ready),
        .m1_address(m1_address), .m1_wstrobe(m1_wstrobe),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_irq(m1_irq),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_address(s_address), .s_wstrobe(s_wstrobe),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_irq(s_irq),
        .grant(grant), .busy(busy),
        .count0(count0), .count1(count1)
    );

    bus_arbiter #(.IRQ_TARGET(1), .COUNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(b_m0_ready),
        .m0_address(m0_address), .m0_wstrobe(m0_wstrobe),
        .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata), .m0_irq(b_m0_irq),
        .m1_valid(m1_valid), .m1_ready(b_m1_ready),
        .m1_address(m1_address), .m1_wstrobe(m1_wstrobe),
        .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata), .m1_irq(b_m1_irq),
        .s_valid(b_s_valid), .s_ready(s_ready),
        .s_address(b_s_address), .s_wstrobe(b_s_wstrobe),
        .s_wdata(b_s_wdata), .s_rdata(s_rdata), .s_irq(s_irq),
        .grant(b_grant), .busy(b_busy),
        .count0(b_count0), .count1(b_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid   = 1'b0;
        m0_address = '0;
        m0_wstrobe = '0;
        m0_wdata   = '0;
        m1_valid   = 1'b0;
        m1_address = '0;
        m1_wstrobe = '0;
        m1_wdata   = '0;
        s_ready    = 1'b0;
        s_rdata    = '0;
        s_irq      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs grant=%b busy=%b s_valid=%b want 00 0 0",
                     grant, busy, s_valid);
        end
        checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready m0=%b m1=%b want 0 0", m0_ready, m1_ready);
        end
        checks++;
        if (count0 !== 32'd0 || count1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts c0=%0d c1=%0d want 0 0", count0, count1);
        end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        m0_valid   = 1'b1;
        m0_address = 32'h100;
        s_ready    = 1'b1;
        s_rdata    = 32'hDEADBEEF;
        #1;
        checks++;
        if (grant !== 2'b00 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_c0 grant=%b s_valid=%b want 00 0", grant, s_valid);
        end
        step();
        checks++;
        if (grant !== 2'b01 || s_valid !== 1'b1 || s_address !== 32'h100) begin
            errors++;
            $display("FAIL single_c1 grant=%b s_valid=%b addr=%h want 01 1 100",
                     grant, s_valid, s_address);
        end
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready m0r=%b rdata=%h m1r=%b want 1 deadbeef 0",
                     m0_ready, m0_rdata, m1_ready);
        end
        step();
        m0_valid = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || count0 !== 32'd1 || m1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_c2 grant=%b count0=%0d m1r=%b want 00 1 0",
                     grant, count0, m1_ready);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_g [8];
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        do_reset();
        m0_valid   = 1'b1;
        m0_address = 32'hA0;
        m1_valid   = 1'b1;
        m1_address = 32'hB0;
        s_ready    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (grant !== exp_g[i]) begin
                errors++;
                $display("FAIL simul_grant cycle %0d grant=%b want %b",
                         i + 1, grant, exp_g[i]);
            end
        end
        checks++;
        if (count0 !== 32'd2 || count1 !== 32'd2) begin
            errors++;
            $display("FAIL simul_counts c0=%0d c1=%0d want 2 2", count0, count1);
        end
        idle_inputs();
    endtask

    task automatic test_wait_states();
        do_reset();
        m1_valid   = 1'b1;
        m1_address = 32'h200;
        m1_wdata   = 32'h12345678;
        m1_wstrobe = 4'hF;
        m0_address = 32'h300;
        m0_wdata   = 32'hCAFEF00D;
        m0_wstrobe = 4'h3;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 2) m0_valid = 1'b1;
            if (i == 4) s_ready = 1'b1;
            #1;
            checks++;
            if (grant !== 2'b10 || s_address !== 32'h200 ||
                s_wdata !== 32'h12345678 || s_wstrobe !== 4'hF) begin
                errors++;
                $display("FAIL wait_hold cycle %0d grant=%b addr=%h wdata=%h ws=%h want 10 200 12345678 f",
                         i, grant, s_address, s_wdata, s_wstrobe);
            end
            checks++;
            if (m0_ready !== 1'b0 || m1_ready !== (i == 4)) begin
                errors++;
                $display("FAIL wait_ready cycle %0d m0r=%b m1r=%b want 0 %0b",
                         i, m0_ready, m1_ready, i == 4);
            end
        end
        step();
        m1_valid = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || count1 !== 32'd1 || count0 !== 32'd0) begin
            errors++;
            $display("FAIL wait_idle grant=%b c1=%0d c0=%0d want 00 1 0",
                     grant, count1, count0);
        end
        step();
        checks++;
        if (grant !== 2'b01 || s_address !== 32'h300 || m0_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_m0_grant grant=%b addr=%h m0r=%b want 01 300 1",
                     grant, s_address, m0_ready);
        end
        step();
        m0_valid = 1'b0;
        #1;
        checks++;
        if (count0 !== 32'd1) begin
            errors++;
            $display("FAIL wait_count0 c0=%0d want 1", count0);
        end
        idle_inputs();
    endtask

    task automatic test_abandon();
        do_reset();
        m0_valid   = 1'b1;
        m0_address = 32'h44;
        step();
        checks++;
        if (grant !== 2'b01 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL abandon_grant grant=%b s_valid=%b want 01 1", grant, s_valid);
        end
        m0_valid = 1'b0;
        #1;
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL abandon_svalid s_valid=%b want 0", s_valid);
        end
        step();
        checks++;
        if (grant !== 2'b00 || count0 !== 32'd0) begin
            errors++;
            $display("FAIL abandon_idle grant=%b c0=%0d want 00 0", grant, count0);
        end
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL abandon_tie grant=%b want 01", grant);
        end
        s_ready = 1'b1;
        step();
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        #1;
        checks++;
        if (count0 !== 32'd1 || count1 !== 32'd0) begin
            errors++;
            $display("FAIL abandon_counts c0=%0d c1=%0d want 1 0", count0, count1);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        // last is 0 and count0 is 1 from the previous scenario
        m1_valid   = 1'b1;
        m1_address = 32'h500;
        step();
        checks++;
        if (grant !== 2'b10 || s_valid !== 1'b1 || count0 !== 32'd1) begin
            errors++;
            $display("FAIL rmid_own1 grant=%b s_valid=%b c0=%0d want 10 1 1",
                     grant, s_valid, count0);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (s_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async s_valid=%b grant=%b busy=%b want 0 00 0",
                     s_valid, grant, busy);
        end
        checks++;
        if (count0 !== 32'd0 || count1 !== 32'd0) begin
            errors++;
            $display("FAIL rmid_counts c0=%0d c1=%0d want 0 0", count0, count1);
        end
        step();
        reset    = 1'b0;
        m0_valid = 1'b1;
        s_ready  = 1'b1;
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL rmid_tie grant=%b want 01", grant);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_irq_wrap();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        s_irq = 1'b1;
        #1;
        checks++;
        if (b_m1_irq !== 1'b1 || b_m0_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_high t1 m1=%b m0=%b want 1 0", b_m1_irq, b_m0_irq);
        end
        checks++;
        if (m0_irq !== 1'b1 || m1_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_high t0 m0=%b m1=%b want 1 0", m0_irq, m1_irq);
        end
        s_irq = 1'b0;
        #1;
        checks++;
        if (b_m1_irq !== 1'b0 || b_m0_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_low m1=%b m0=%b want 0 0", b_m1_irq, b_m0_irq);
        end
        m1_valid   = 1'b1;
        m1_address = 32'h600;
        s_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (b_grant !== 2'b10 || b_m1_ready !== 1'b1) begin
                errors++;
                $display("FAIL wrap_grant xfer %0d grant=%b m1r=%b want 10 1",
                         i, b_grant, b_m1_ready);
            end
            step();
            checks++;
            if (b_count1 !== exp_c[i]) begin
                errors++;
                $display("FAIL wrap_count xfer %0d count1=%0d want %0d",
                         i, b_count1, exp_c[i]);
            end
        end
        checks++;
        if (count1 !== 32'd5 || b_count0 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_wide c1=%0d b_c0=%0d want 5 0", count1, b_count0);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wait_states();
        test_abandon();
        test_reset_mid();
        test_irq_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
